mem_access_controller: RTL and testbench

- Sequences every load/store between the execute stage and a data memory that answers with a variable-latency ack.
- Decodes the MIPS memory opcode and checks alignment.
- Generates the byte enables and write-lane replication, holds the memory request until ack, and extracts and extends load data.
- Stalls the pipeline through o_busy and reports completion or error with a one-cycle o_done pulse.

---
 rtl/mem_access_controller.sv | 175 +++++++++++++++++
 tb/tb_mem_access_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - load/store sequencer between execute stage and a variable-latency data memory
module mem_access_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [CW-1:0] cnt;

  logic        op_valid;
  logic        is_store;
  logic [1:0]  acc_size;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  // Decode of the incoming request; acc_size 0=byte, 1=half, 2=word.
  always_comb begin
    op_valid = 1'b1;
    acc_size = 2'd0;
    case (i_opcode)
      OP_LB, OP_LBU, OP_SB: acc_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: acc_size = 2'd1;
      OP_LW, OP_SW:         acc_size = 2'd2;
      default:              op_valid = 1'b0;
    endcase
    is_store   = i_opcode[3];
    misaligned = ((acc_size == 2'd1) && i_address[0]) ||
                 ((acc_size == 2'd2) && (i_address[1:0] != 2'b00));
    be_n    = 4'b0000;
    wdata_n = 32'd0;
    if (is_store) begin
      case (acc_size)
        2'd0: begin
          be_n    = 4'b0001 << i_address[1:0];
          wdata_n = {4{i_wdata[7:0]}};
        end
        2'd1: begin
          be_n    = i_address[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{i_wdata[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = i_wdata;
        end
      endcase
    end
  end

  // Lane selection and extension of the returned read word.
  always_comb begin
    case (addr_lo_q)
      2'd0:    byte_v = i_mem_rdata[7:0];
      2'd1:    byte_v = i_mem_rdata[15:8];
      2'd2:    byte_v = i_mem_rdata[23:16];
      default: byte_v = i_mem_rdata[31:24];
    endcase
    half_v = addr_lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'd0, byte_v};
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'd0, half_v};
      default: load_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      op_q         <= 6'd0;
      addr_lo_q    <= 2'd0;
      cnt          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rdata      <= 32'd0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= 32'd0;
      o_mem_be     <= 4'd0;
      o_mem_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req && op_valid) begin
            op_q      <= i_opcode;
            addr_lo_q <= i_address[1:0];
            o_busy    <= 1'b1;
            if (misaligned) begin
              state        <= S_ERR;
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
            end else begin
              state       <= S_REQ;
              cnt         <= '0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= is_store;
              o_mem_addr  <= {i_address[31:2], 2'b00};
              o_mem_be    <= be_n;
              o_mem_wdata <= wdata_n;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (i_mem_ack || (cnt == CNT_LAST)) begin
            o_done      <= 1'b1;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
            if (i_mem_ack) begin
              state <= S_DONE;
              if (!op_q[3]) o_rdata <= load_data;
            end else begin
              state     <= S_ERR;
              o_timeout <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          state        <= S_IDLE;
          o_done       <= 1'b0;
          o_misaligned <= 1'b0;
          o_timeout    <= 1'b0;
          o_busy       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - directed vector bench for mem_access_controller
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misaligned, timeout;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_controller #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_opcode(opcode),
    .i_address(address), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_misaligned(misaligned), .o_timeout(timeout),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          ack_at;
    int          lat;
    int          reqs;
    logic [3:0]  be;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        mis;
    logic        to;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Issues one access and observes 12 cycles after the accept edge.
  task automatic run_vec(input vec_t v, input int idx);
    int done_cnt = 0, done_cyc = 0, req_cnt = 0, busy_cnt = 0, unstable = 0, stray = 0;
    logic mis_s = 1'b0, to_s = 1'b0, we_s = 1'b0;
    logic [3:0] be_s = 4'd0;
    logic [31:0] ma_s = 32'd0, mw_s = 32'd0;
    @(negedge clk);
    req = 1'b1; opcode = v.op; address = v.addr; wdata = v.wd;
    mem_rdata = v.mrd; mem_ack = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req = 1'b0;
      if (busy) busy_cnt++;
      if (mem_req) begin
        if (req_cnt == 0) begin
          be_s = mem_be; we_s = mem_we; ma_s = mem_addr; mw_s = mem_wdata;
        end else if (mem_be !== be_s || mem_we !== we_s || mem_addr !== ma_s || mem_wdata !== mw_s) begin
          unstable++;
        end
        req_cnt++;
      end else if (mem_be !== 4'd0 || mem_we !== 1'b0) begin
        stray++;
      end
      if (done) begin
        if (done_cnt == 0) begin
          done_cyc = cyc; mis_s = misaligned; to_s = timeout;
        end
        done_cnt++;
      end else if (misaligned || timeout) begin
        stray++;
      end
      mem_ack = (cyc == v.ack_at);
    end
    mem_ack = 1'b0;
    check("latency", idx, done_cyc, v.lat);
    check("done_count", idx, done_cnt, (v.lat > 0) ? 1 : 0);
    check("busy_cycles", idx, busy_cnt, v.lat);
    check("req_cycles", idx, req_cnt, v.reqs);
    check("mem_be", idx, {28'd0, be_s}, {28'd0, v.be});
    check("mem_we", idx, {31'd0, we_s}, {31'd0, v.we});
    check("mem_addr", idx, ma_s, v.maddr);
    check("mem_wdata", idx, mw_s, v.mwd);
    check("misaligned", idx, {31'd0, mis_s}, {31'd0, v.mis});
    check("timeout", idx, {31'd0, to_s}, {31'd0, v.to});
    check("rdata", idx, rdata, v.rd);
    check("stable", idx, unstable, 0);
    check("idle_outputs", idx, stray, 0);
  endtask

  initial begin
    //        op        addr          wd            mrd           ack lat req be       we    maddr         mwd           mis   to    rd
    vt[0]  = '{6'b101011, 32'h100, 32'hDEADBEEF, 32'h0,        1, 2, 1, 4'b1111, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{6'b101000, 32'h203, 32'h000000A5, 32'h0,        3, 4, 3, 4'b1000, 1'b1, 32'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{6'b100000, 32'h1,   32'h0,        32'h80FF7F01, 1, 2, 1, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0000007F};
    vt[3]  = '{6'b100000, 32'h3,   32'h0,        32'h80FF7F01, 1, 2, 1, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hFFFFFF80};
    vt[4]  = '{6'b100100, 32'h3,   32'h0,        32'h80FF7F01, 1, 2, 1, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h00000080};
    vt[5]  = '{6'b100001, 32'h2,   32'h0,        32'h80FF7F01, 1, 2, 1, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hFFFF80FF};
    vt[6]  = '{6'b100101, 32'h0,   32'h0,        32'h80FF7F01, 1, 2, 1, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h00007F01};
    vt[7]  = '{6'b100011, 32'h4,   32'h0,        32'h80FF7F01, 1, 2, 1, 4'b0000, 1'b0, 32'h4,   32'h0,        1'b0, 1'b0, 32'h80FF7F01};
    vt[8]  = '{6'b101001, 32'h102, 32'h00001234, 32'h0,        2, 3, 2, 4'b1100, 1'b1, 32'h100, 32'h12341234, 1'b0, 1'b0, 32'h80FF7F01};
    vt[9]  = '{6'b100011, 32'h102, 32'h0,        32'h0,        1, 1, 0, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h80FF7F01};
    vt[10] = '{6'b101001, 32'h101, 32'h0,        32'h0,        1, 1, 0, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h80FF7F01};
    vt[11] = '{6'b101011, 32'h40,  32'h00000001, 32'h0,        0, 5, 4, 4'b1111, 1'b1, 32'h40,  32'h00000001, 1'b0, 1'b1, 32'h80FF7F01};
    vt[12] = '{6'b100011, 32'h8,   32'h0,        32'h13579BDF, 4, 5, 4, 4'b0000, 1'b0, 32'h8,   32'h0,        1'b0, 1'b0, 32'h13579BDF};
    vt[13] = '{6'b000000, 32'h10,  32'h0,        32'h0,        1, 0, 0, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h13579BDF};
    vt[14] = '{6'b101000, 32'h1,   32'hFFFFFF3C, 32'h0,        1, 2, 1, 4'b0010, 1'b1, 32'h0,   32'h3C3C3C3C, 1'b0, 1'b0, 32'h13579BDF};

    repeat (2) @(negedge clk);
    check("reset_busy", 0, {31'd0, busy}, 32'd0);
    check("reset_done", 0, {31'd0, done}, 32'd0);
    check("reset_mem_req", 0, {31'd0, mem_req}, 32'd0);
    check("reset_rdata", 0, rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", 0,
          {busy, done, misaligned, timeout, mem_req, mem_we, mem_be, 22'd0},
          32'd0);
    check("post_reset_bus", 0, mem_addr | mem_wdata, 32'd0);

    for (int i = 0; i < 15; i++) run_vec(vt[i], i);

    // Reset asserted during the second REQ cycle of a store.
    @(negedge clk);
    req = 1'b1; opcode = 6'b101011; address = 32'h300; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    check("rst_req_cycle1", 100, {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    check("rst_req_cycle2", 100, {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", 100, {31'd0, mem_req}, 32'd0);
    check("rst_busy", 100, {31'd0, busy}, 32'd0);
    check("rst_done", 100, {31'd0, done}, 32'd0);
    check("rst_rdata", 100, rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0], 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
